// File: rtl/core_host_if.sv
// ---------------------------------------------------------------------------
// core_host_if
// Bundles every core_host signal except clk/reset.
//   master : the sequencer side (core_host drives the outputs listed there).
//   slave  : the environment side (harness/bus, data memory and the core).
// Signal groups:
//   run control : start, ld_base, ld_count, rd_base, rd_count, busy, timeout
//   operand in  : in_valid, in_data, in_ready
//   memory port : mem_wr_en, mem_addr, mem_wr_dat, mem_rd_dat
//   core        : req, done
//   result out  : out_valid, out_data, out_ready
// ---------------------------------------------------------------------------
interface core_host_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          start;
    logic [AW-1:0] ld_base;
    logic [AW-1:0] ld_count;
    logic [AW-1:0] rd_base;
    logic [AW-1:0] rd_count;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wr_dat;
    logic [DW-1:0] mem_rd_dat;
    logic          req;
    logic          done;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          busy;
    logic          timeout;

    modport master (
        input  start, ld_base, ld_count, rd_base, rd_count,
        input  in_valid, in_data, mem_rd_dat, done, out_ready,
        output in_ready, mem_wr_en, mem_addr, mem_wr_dat,
        output req, out_valid, out_data, busy, timeout
    );

    modport slave (
        output start, ld_base, ld_count, rd_base, rd_count,
        output in_valid, in_data, mem_rd_dat, done, out_ready,
        input  in_ready, mem_wr_en, mem_addr, mem_wr_dat,
        input  req, out_valid, out_data, busy, timeout
    );
endinterface

// File: rtl/core_host.sv
// ---------------------------------------------------------------------------
// core_host
// Host-side sequencer for the processor core: loads operand words into the
// core's data memory, raises req, waits for done under a watchdog, then
// streams a window of result words back out of data memory.
// Ports:
//   clk   : sole clock, rising edge
//   reset : asynchronous, active-high
//   bus   : core_host_if.master (run control, operand stream, memory port,
//           core handshake, result stream)
// Parameters: AW address width, DW data width, TIMEOUT RUN-cycle limit,
//             CW watchdog width (2**CW > TIMEOUT).
// ---------------------------------------------------------------------------
module core_host #(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int TIMEOUT = 4096,
    parameter int CW      = 13
) (
    input  logic        clk,
    input  logic        reset,
    core_host_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LAUNCH,
        S_RUN,
        S_DRAIN
    } state_t;

    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_ld_base;
    logic [AW-1:0] r_ld_count;
    logic [AW-1:0] r_rd_base;
    logic [AW-1:0] r_rd_count;
    logic [AW-1:0] r_idx;       // shared beat index for LOAD and DRAIN
    logic [CW-1:0] r_wdog;
    logic          r_timeout;

    logic [AW-1:0] w_ld_last;
    logic [AW-1:0] w_rd_last;
    logic          w_wd_expire;

    assign w_ld_last   = r_ld_count - AW'(1);
    assign w_rd_last   = r_rd_count - AW'(1);
    // done has priority: expiry only counts when the core has not finished.
    assign w_wd_expire = (r_state == S_RUN) && !bus.done && (r_wdog == WD_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every output and the next state get a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt    = r_state;
        bus.busy       = (r_state != S_IDLE);
        bus.req        = 1'b0;
        bus.in_ready   = 1'b0;
        bus.out_valid  = 1'b0;
        bus.mem_wr_en  = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wr_dat = bus.in_data;
        bus.out_data   = bus.mem_rd_dat;
        bus.timeout    = r_timeout;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = (bus.ld_count != '0) ? S_LOAD : S_LAUNCH;
                end
            end
            S_LOAD: begin
                bus.in_ready  = 1'b1;
                bus.mem_wr_en = bus.in_valid;
                bus.mem_addr  = r_ld_base + r_idx;
                if (bus.in_valid && (r_idx == w_ld_last)) begin
                    w_state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                // done may still be high from the previous run; ignore it.
                bus.req     = 1'b1;
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                bus.req = 1'b1;
                if (bus.done) begin
                    w_state_nxt = (r_rd_count != '0) ? S_DRAIN : S_IDLE;
                end else if (w_wd_expire) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DRAIN: begin
                bus.out_valid = 1'b1;
                bus.mem_addr  = r_rd_base + r_idx;
                if (bus.out_ready && (r_idx == w_rd_last)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ld_base  <= '0;
            r_ld_count <= '0;
            r_rd_base  <= '0;
            r_rd_count <= '0;
            r_idx      <= '0;
            r_wdog     <= '0;
            r_timeout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_ld_base  <= bus.ld_base;
                        r_ld_count <= bus.ld_count;
                        r_rd_base  <= bus.rd_base;
                        r_rd_count <= bus.rd_count;
                        r_idx      <= '0;
                        r_timeout  <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (bus.in_valid) begin
                        // Rewind on the last beat so DRAIN starts at index 0.
                        r_idx <= (r_idx == w_ld_last) ? '0 : r_idx + AW'(1);
                    end
                end
                S_LAUNCH: begin
                    r_wdog <= '0;
                end
                S_RUN: begin
                    r_wdog <= r_wdog + CW'(1);
                    if (w_wd_expire) begin
                        r_timeout <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (bus.out_ready) begin
                        r_idx <= r_idx + AW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
